// File: rtl/bt_update_queue.sv
// Purpose : in-order FIFO of branch-target updates feeding the BTB insert port, with duplicate-src filtering and a saturating drop counter.
// Latency : an update written in cycle t is visible on OUT_* in cycle t+1 (head outputs are combinational from storage).
// Backpress: IN_ready stalls the head; inputs beyond free space (sampled before the pop) are dropped and counted.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   IN_upValid/Src/Dst/IsJump/Compr per-source update bundle (NUM_IN sources)
//   IN_flush                        synchronous clear of all queued updates
//   IN_ready                        predictor consumes the head this cycle
//   OUT_valid/src/dst/isJump/compr  head update
//   OUT_count, OUT_full             occupancy
//   OUT_dropCount                   saturating count of overflow drops
module bt_update_queue #(
    parameter int NUM_IN   = 2,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IN-1:0]             IN_upValid,
    input  logic [NUM_IN-1:0][31:0]       IN_upSrc,
    input  logic [NUM_IN-1:0][31:0]       IN_upDst,
    input  logic [NUM_IN-1:0]             IN_upIsJump,
    input  logic [NUM_IN-1:0]             IN_upCompr,
    input  logic                          IN_flush,
    input  logic                          IN_ready,
    output logic                          OUT_valid,
    output logic [31:0]                   OUT_src,
    output logic [31:0]                   OUT_dst,
    output logic                          OUT_isJump,
    output logic                          OUT_compr,
    output logic [$clog2(DEPTH):0]        OUT_count,
    output logic                          OUT_full,
    output logic [CNT_BITS-1:0]           OUT_dropCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_BITS + 2;
    localparam logic [SUM_W-1:0] DROP_MAX = {2'b00, {CNT_BITS{1'b1}}};

    logic [31:0]      srcMem   [DEPTH];
    logic [31:0]      dstMem   [DEPTH];
    logic             jumpMem  [DEPTH];
    logic             comprMem [DEPTH];

    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic [CNT_BITS-1:0] dropCount;

    logic [DEPTH-1:0]  occupied;
    logic [NUM_IN-1:0] isCand;
    logic [NUM_IN-1:0] wrGo;
    logic [PTR_W-1:0]  wrSlot [NUM_IN];
    logic [PTR_W:0]    freeSpace;
    logic [PTR_W:0]    numWritten;
    logic [SUM_W-1:0]  numDropped;
    logic [SUM_W-1:0]  dropSum;
    logic              doPop;

    assign OUT_valid     = (count != '0);
    assign OUT_src       = srcMem[rdPtr];
    assign OUT_dst       = dstMem[rdPtr];
    assign OUT_isJump    = jumpMem[rdPtr];
    assign OUT_compr     = comprMem[rdPtr];
    assign OUT_count     = count;
    assign OUT_full      = (count == (PTR_W+1)'(DEPTH));
    assign OUT_dropCount = dropCount;

    assign doPop = OUT_valid && IN_ready && !IN_flush;

    // A slot holds live data when its distance from the read pointer is
    // below the occupancy; this includes the head being popped this cycle.
    always_comb begin
        logic [PTR_W-1:0] offset;
        occupied = '0;
        offset   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            offset      = PTR_W'(k) - rdPtr;
            occupied[k] = ({1'b0, offset} < count);
        end
    end

    // Candidate selection and slot allocation. Space is taken from the
    // pre-pop occupancy, so a same-cycle pop never frees room for inserts.
    // Dropped candidates still shadow later inputs with the same src.
    always_comb begin
        isCand     = '0;
        wrGo       = '0;
        numWritten = '0;
        numDropped = '0;
        freeSpace  = (PTR_W+1)'(DEPTH) - count;
        for (int i = 0; i < NUM_IN; i++) begin
            wrSlot[i] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            isCand[i] = IN_upValid[i];
            for (int k = 0; k < DEPTH; k++) begin
                if (occupied[k] && (srcMem[k] == IN_upSrc[i])) begin
                    isCand[i] = 1'b0;
                end
            end
            for (int j = 0; j < i; j++) begin
                if (isCand[j] && (IN_upSrc[j] == IN_upSrc[i])) begin
                    isCand[i] = 1'b0;
                end
            end
            if (isCand[i]) begin
                if (numWritten < freeSpace) begin
                    wrGo[i]    = 1'b1;
                    wrSlot[i]  = wrPtr + numWritten[PTR_W-1:0];
                    numWritten = numWritten + (PTR_W+1)'(1);
                end else begin
                    numDropped = numDropped + SUM_W'(1);
                end
            end
        end
        dropSum = SUM_W'(dropCount) + numDropped;
    end

    // Storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (!IN_flush) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (wrGo[i]) begin
                    srcMem[wrSlot[i]]   <= IN_upSrc[i];
                    dstMem[wrSlot[i]]   <= IN_upDst[i];
                    jumpMem[wrSlot[i]]  <= IN_upIsJump[i];
                    comprMem[wrSlot[i]] <= IN_upCompr[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            dropCount <= '0;
        end else if (IN_flush) begin
            // Flush-discarded inputs are not overflow losses: counter holds.
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= rdPtr + PTR_W'(doPop);
            // numWritten can equal DEPTH; its low bits then wrap to zero.
            wrPtr <= wrPtr + numWritten[PTR_W-1:0];
            count <= count + numWritten - (PTR_W+1)'(doPop);
            if (dropSum > DROP_MAX) begin
                dropCount <= {CNT_BITS{1'b1}};
            end else begin
                dropCount <= dropSum[CNT_BITS-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bt_update_queue.sv
// Bench for bt_update_queue: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_bt_update_queue;

    localparam int NUM_IN   = 2;
    localparam int DEPTH    = 4;
    localparam int CNT_BITS = 8;
    localparam int DROP_SAT = 255;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_IN-1:0]       upValid;
    logic [NUM_IN-1:0][31:0] upSrc;
    logic [NUM_IN-1:0][31:0] upDst;
    logic [NUM_IN-1:0]       upIsJump;
    logic [NUM_IN-1:0]       upCompr;
    logic                    flush;
    logic                    ready;
    logic                    outValid;
    logic [31:0]             outSrc;
    logic [31:0]             outDst;
    logic                    outIsJump;
    logic                    outCompr;
    logic [$clog2(DEPTH):0]  outCount;
    logic                    outFull;
    logic [CNT_BITS-1:0]     outDropCount;

    always #5 clk = ~clk;

    bt_update_queue #(.NUM_IN(NUM_IN), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .IN_upValid(upValid), .IN_upSrc(upSrc), .IN_upDst(upDst),
        .IN_upIsJump(upIsJump), .IN_upCompr(upCompr),
        .IN_flush(flush), .IN_ready(ready),
        .OUT_valid(outValid), .OUT_src(outSrc), .OUT_dst(outDst),
        .OUT_isJump(outIsJump), .OUT_compr(outCompr),
        .OUT_count(outCount), .OUT_full(outFull), .OUT_dropCount(outDropCount)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic        isJump;
        logic        compr;
    } ent_t;

    ent_t mq[$];
    int   mDrop = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge with the inputs currently driven.
    task automatic modelStep();
        ent_t cands[$];
        ent_t e;
        int   freeSpace;
        bit   dup;
        bit   pop;
        if (flush) begin
            mq.delete();
            return;
        end
        freeSpace = DEPTH - mq.size();
        pop = (mq.size() != 0) && ready;
        for (int i = 0; i < NUM_IN; i++) begin
            if (upValid[i]) begin
                dup = 1'b0;
                foreach (mq[k]) if (mq[k].src == upSrc[i]) dup = 1'b1;
                foreach (cands[k]) if (cands[k].src == upSrc[i]) dup = 1'b1;
                if (!dup) begin
                    e.src = upSrc[i]; e.dst = upDst[i];
                    e.isJump = upIsJump[i]; e.compr = upCompr[i];
                    cands.push_back(e);
                end
            end
        end
        if (pop) void'(mq.pop_front());
        foreach (cands[k]) begin
            if (k < freeSpace) mq.push_back(cands[k]);
            else if (mDrop < DROP_SAT) mDrop++;
        end
    endtask

    task automatic checkAll(input string ctx);
        chk({ctx, ".valid"}, 32'(outValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({ctx, ".src"},    outSrc,           mq[0].src);
            chk({ctx, ".dst"},    outDst,           mq[0].dst);
            chk({ctx, ".isJump"}, 32'(outIsJump),   32'(mq[0].isJump));
            chk({ctx, ".compr"},  32'(outCompr),    32'(mq[0].compr));
        end
        chk({ctx, ".count"}, 32'(outCount),     32'(mq.size()));
        chk({ctx, ".full"},  32'(outFull),      32'(mq.size() == DEPTH));
        chk({ctx, ".drop"},  32'(outDropCount), 32'(mDrop));
    endtask

    // One clock: model follows the edge, outputs are checked 1 time unit later.
    task automatic cycle(input string ctx);
        @(posedge clk);
        modelStep();
        #1;
        checkAll(ctx);
    endtask

    task automatic clrIn();
        upValid = '0; upSrc = '0; upDst = '0; upIsJump = '0; upCompr = '0;
        flush = 1'b0;
    endtask

    task automatic drive(input int i, input logic [31:0] s, input logic [31:0] d,
                         input logic j, input logic c);
        upValid[i] = 1'b1; upSrc[i] = s; upDst[i] = d;
        upIsJump[i] = j; upCompr[i] = c;
    endtask

    initial begin
        clrIn();
        ready = 1'b0;

        // Reset and single update
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        chk("reset.valid", 32'(outValid), 32'd0);
        chk("reset.drop",  32'(outDropCount), 32'd0);
        rst_n = 1'b1;
        drive(0, 32'h100, 32'h200, 1'b1, 1'b0);
        cycle("single.t1");
        chk("single.src", outSrc, 32'h100);
        chk("single.dst", outDst, 32'h200);
        clrIn();
        ready = 1'b1;
        cycle("single.t2");
        chk("single.empty", 32'(outValid), 32'd0);

        // Simultaneous distinct updates
        ready = 1'b0;
        drive(0, 32'h10, 32'hA10, 1'b0, 1'b1);
        drive(1, 32'h20, 32'hA20, 1'b1, 1'b0);
        cycle("dual.ins");
        clrIn();
        chk("dual.peak", 32'(outCount), 32'd2);
        chk("dual.first", outSrc, 32'h10);
        ready = 1'b1;
        cycle("dual.pop1");
        chk("dual.second", outSrc, 32'h20);
        cycle("dual.pop2");

        // Duplicate filtering
        ready = 1'b0;
        drive(0, 32'h40, 32'hB0, 1'b0, 1'b0);
        drive(1, 32'h40, 32'hB1, 1'b1, 1'b1);
        cycle("dup.same");
        chk("dup.count1", 32'(outCount), 32'd1);
        clrIn();
        drive(0, 32'h40, 32'hB2, 1'b0, 1'b0);
        cycle("dup.queued");
        chk("dup.count2", 32'(outCount), 32'd1);
        chk("dup.nodrop", 32'(outDropCount), 32'd0);
        clrIn();
        flush = 1'b1;
        cycle("dup.flush");
        flush = 1'b0;

        // Wrap-around streaming
        ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            clrIn();
            drive(0, 32'h3000 + 32'(n), 32'h4000 + 32'(n), 1'b0, 1'b0);
            cycle("wrap");
            chk("wrap.order", outSrc, 32'h3000 + 32'(n));
            chk("wrap.maxcnt", 32'(outCount <= 1), 32'd1);
        end
        clrIn();
        cycle("wrap.drain");
        chk("wrap.nodrop", 32'(outDropCount), 32'd0);

        // Flush with concurrent insert and pop
        ready = 1'b0;
        drive(0, 32'h50, 32'h1, 1'b0, 1'b0);
        drive(1, 32'h51, 32'h2, 1'b0, 1'b0);
        cycle("flush.q2");
        clrIn();
        drive(0, 32'h52, 32'h3, 1'b0, 1'b0);
        cycle("flush.q3");
        clrIn();
        drive(0, 32'h53, 32'h4, 1'b1, 1'b1);
        flush = 1'b1;
        ready = 1'b1;
        cycle("flush.do");
        chk("flush.count", 32'(outCount), 32'd0);
        chk("flush.absent", 32'(outValid), 32'd0);

        // Async reset between edges
        clrIn();
        ready = 1'b0;
        drive(0, 32'h60, 32'h5, 1'b0, 1'b0);
        drive(1, 32'h61, 32'h6, 1'b0, 1'b0);
        cycle("areset.q2");
        clrIn();
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mDrop = 0;
        chk("areset.valid", 32'(outValid), 32'd0);
        chk("areset.count", 32'(outCount), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 32'h70, 32'h7, 1'b0, 1'b1);
        cycle("areset.after");
        chk("areset.first", outSrc, 32'h70);
        chk("areset.firstcnt", 32'(outCount), 32'd1);
        clrIn();
        flush = 1'b1;
        cycle("areset.flush");
        flush = 1'b0;

        // Overflow and saturation
        ready = 1'b0;
        drive(0, 32'h1000, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h1001, 32'h0, 1'b0, 1'b0);
        cycle("ovf.fill1");
        drive(0, 32'h1002, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h1003, 32'h0, 1'b0, 1'b0);
        cycle("ovf.fill2");
        drive(0, 32'h1004, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h1005, 32'h0, 1'b0, 1'b0);
        cycle("ovf.first");
        chk("ovf.full", 32'(outFull), 32'd1);
        chk("ovf.drop2", 32'(outDropCount), 32'd2);
        ready = 1'b1;
        drive(0, 32'h1006, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h1007, 32'h0, 1'b0, 1'b0);
        cycle("ovf.fullpop");
        chk("ovf.popnoroom", 32'(outDropCount), 32'd4);
        chk("ovf.count3", 32'(outCount), 32'd3);
        clrIn();
        drive(0, 32'h1008, 32'h0, 1'b0, 1'b0);
        ready = 1'b0;
        cycle("ovf.refill");
        for (int n = 0; n < 126; n++) begin
            drive(0, 32'h2000 + 32'(2 * n), 32'h0, 1'b0, 1'b0);
            drive(1, 32'h2001 + 32'(2 * n), 32'h0, 1'b0, 1'b0);
            cycle("ovf.loop");
        end
        chk("ovf.sat", 32'(outDropCount), 32'd255);
        drive(0, 32'h2F00, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h2F01, 32'h0, 1'b0, 1'b0);
        cycle("ovf.past");
        chk("ovf.hold", 32'(outDropCount), 32'd255);
        clrIn();
        flush = 1'b1;
        cycle("ovf.flush");
        chk("ovf.flushkeep", 32'(outDropCount), 32'd255);

        // Randomized traffic with a small src pool to provoke duplicates
        for (int n = 0; n < 400; n++) begin
            clrIn();
            for (int i = 0; i < NUM_IN; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    drive(i, 32'h8000 + 32'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            flush = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bt_update_queue.md
# bt_update_queue

Buffers branch-target updates from the branch execution units and feeds them one per cycle into the branch predictor's BTB insert port. Without this block, simultaneous updates from several units collide and all but one are lost. The queue keeps a small in-order FIFO, drops duplicate source addresses, and counts overflow losses for performance CSRs. It sits between the branch XUs and the predictor's update input.

## Interface

Parameters
- NUM_IN, 2: number of update sources (branch XUs).
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- CNT_BITS, 8: width of the saturating drop counter.

Ports
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IN_upValid  input  NUM_IN  per-source update valid.
- IN_upSrc  input  NUM_IN x 32  per-source branch source address.
- IN_upDst  input  NUM_IN x 32  per-source branch target address.
- IN_upIsJump  input  NUM_IN  per-source flag: unconditional jump.
- IN_upCompr  input  NUM_IN  per-source flag: compressed instruction.
- IN_flush  input  1  synchronous clear of all queued updates.
- IN_ready  input  1  predictor accepts the head update this cycle.
- OUT_valid  output  1  head update present.
- OUT_src  output  32  head source address.
- OUT_dst  output  32  head target address.
- OUT_isJump  output  1  head jump flag.
- OUT_compr  output  1  head compressed flag.
- OUT_count  output  log2(DEPTH)+1  occupied entries.
- OUT_full  output  1  OUT_count == DEPTH.
- OUT_dropCount  output  CNT_BITS  overflow drops; saturating.

## Operation

- Storage is a circular FIFO with read pointer, write pointer (log2(DEPTH) bits, natural wrap) and an occupancy count.
- Head outputs come combinationally from the entry at the read pointer. OUT_valid = (count != 0). When OUT_valid is 0, the data outputs are don't-care.
- Pop: occurs when OUT_valid && IN_ready && !IN_flush. The read pointer advances by 1.
- Insert candidates: an input i is a candidate when IN_upValid[i] is 1 and both of the following hold:
  - its src differs from the src of every occupied entry, including the head being popped this cycle;
  - its src differs from the src of every lower-indexed candidate in the same cycle.
- An input that fails either check is a duplicate. It is discarded silently and is not counted.
- Free space = DEPTH − count, sampled before this cycle's pop. A pop does not make room for same-cycle inserts.
- Candidates are written in ascending index order at consecutive write-pointer slots, up to the free space. The write pointer advances by the number written.
- Candidates beyond the free space are dropped. OUT_dropCount increments by the number dropped and saturates at 2^CNT_BITS − 1.
- Next count = count + written − popped.
- Flush: IN_flush = 1 sets count, read pointer and write pointer to 0 and discards all same-cycle inserts and the pop. Discards caused by flush are not counted. OUT_dropCount is unaffected.
- Reset (rst_n low, asynchronous): count = 0, both pointers = 0, OUT_dropCount = 0. Consequently OUT_valid = 0, OUT_count = 0 and OUT_full = 0 immediately. Storage contents need no reset.
- Reset that asserts mid-operation discards all queued updates. The first input sampled after rst_n rises is handled as into an empty queue.

## Timing

- Latency: an update presented in cycle t to an empty queue appears on OUT_* in cycle t+1. If IN_ready is high in t+1, it is consumed in t+1.
- Throughput: one pop per cycle. Up to min(NUM_IN, free space) inserts per cycle.
- When the queue is full and IN_ready is high, an input in the same cycle is still dropped, because space is sampled before the pop.
- OUT_count, OUT_full and OUT_dropCount are registered state and reflect the previous edge.
- The head entry is stable while OUT_valid && !IN_ready.

## Test plan

- Reset and single update: hold rst_n low, then release. Check OUT_valid = 0 and OUT_dropCount = 0. Drive source 0 with src = 0x100, dst = 0x200, isJump = 1 in cycle t. Require OUT_valid = 1, OUT_src = 0x100, OUT_dst = 0x200 in t+1. With IN_ready = 1, require OUT_valid = 0 in t+2.
- Simultaneous distinct updates: with IN_ready = 0, drive sources 0 and 1 with src 0x10 and 0x20. Then raise IN_ready. Require output order 0x10 then 0x20 and a peak OUT_count of 2.
- Duplicate filtering: source 0 and source 1 both drive src 0x40 in the same cycle. Require one entry only. Next cycle, drive 0x40 again while it is still queued. Require OUT_count to stay at 1 and OUT_dropCount to stay at 0.
- Overflow and saturation (DEPTH = 4): with IN_ready = 0, fill the queue with 4 distinct srcs, then drive 2 more distinct srcs. Require OUT_full = 1 and OUT_dropCount = 2. Repeat overflows until OUT_dropCount = 255, then one more overflow: require it to stay at 255.
- Wrap-around: stream 10 distinct updates, one per cycle, with IN_ready = 1 continuously. Require all 10 in order, OUT_count never above 1, and no drops.
- Flush and async reset: queue 3 entries. Assert IN_flush together with a new input and IN_ready = 1. Require OUT_count = 0 next cycle and the new input absent. Queue 2 entries again, then pulse rst_n low between clock edges. Require OUT_valid = 0 before the next edge.
